breathe_gen: RTL and testbench
==============================

Name: breathe_gen

Overview:
Upstream source for the 8-bit PWM stage. Generates a slowly ramping triangle "breathing" envelope with dwell at the top and bottom, optionally gamma-shaped. Drives the PWM compare input in place of a free-running counter, so the LEDs fade smoothly instead of sawtoothing.

Parameters:
CTR_LEN, 8, width of level/value; must match the PWM stage CTR_LEN
DIV_LEN, 16, width of step_div prescaler input
HOLD_STEPS, 32, ticks spent dwelling at max and at zero; legal range 1..2^16-1
GAMMA, 0, 0 = value is linear level; 1 = value = (level*level) >> CTR_LEN

Ports:
clk  in  1  system clock (50 MHz)
rst_n  in  1  reset, asynchronous, active-low
en  in  1  run enable; low forces IDLE
step_div  in  DIV_LEN  tick period minus one; a tick occurs every step_div+1 cycles
value  out  CTR_LEN  compare value to PWM stage, registered
dir  out  1  1 while rising or holding high, 0 otherwise
peak  out  1  one-cycle pulse when level reaches MAX
trough  out  1  one-cycle pulse when level returns to 0

Behaviour:
- One clock; rst_n is asynchronous and active-low. All flops clear on rst_n low, independent of clk.
- Reset values: value=0, dir=0, peak=0, trough=0, level=0, prescaler=0, hold_cnt=0, state=IDLE.
- MAX = 2^CTR_LEN-1.
- Prescaler: pre increments each cycle in non-IDLE states.
  - tick = (pre >= step_div); on tick pre<=0.
  - step_div=0 gives a tick every cycle.
  - Lowering step_div below pre ticks on the next cycle, with no wrap-around.
- States: IDLE, RISE, HOLD_HI, FALL, HOLD_LO.
- IDLE: when en=1, go to RISE next cycle with level=0 and pre=0.
- RISE, on tick: level<=level+1. If level==MAX-1, go to HOLD_HI, hold_cnt<=0, and pulse peak for one cycle, coincident with level becoming MAX.
- HOLD_HI, on tick: hold_cnt+1. When hold_cnt==HOLD_STEPS-1, go to FALL.
- FALL, on tick: level<=level-1. If level==1, go to HOLD_LO, hold_cnt<=0, and pulse trough for one cycle.
- HOLD_LO, on tick: same as HOLD_HI, then go to RISE.
- Steady-state period: 2*MAX + 2*HOLD_STEPS ticks.
- Level never wraps: it saturates by construction at MAX and 0.
- en=0 in any state:
  - next cycle is IDLE with level=0, pre=0, hold_cnt=0;
  - peak and trough forced 0;
  - value follows level to 0 with normal latency.
  - en re-asserted restarts from level 0.
- Output latency: value is registered from level, one cycle behind level.
  - GAMMA=0: value=level.
  - GAMMA=1: value=(level*level)>>CTR_LEN, using a 2*CTR_LEN-bit product, truncated, no rounding.
  - Example GAMMA=1: 255->254, 128->64, 15->0.
- dir is 1 in RISE and HOLD_HI, 0 in IDLE, FALL and HOLD_LO. dir is registered with the state.
- Simultaneous en falling and tick: en wins. No step occurs and no pulse is issued.
- Reset asserted mid-ramp: outputs go to reset values immediately (asynchronously). Operation restarts from IDLE after release.

Decomposition:
- Shared header: state encodings (3-bit localparams IDLE=0, RISE=1, HOLD_HI=2, FALL=3, HOLD_LO=4).
- Shared header: MAX derivation from CTR_LEN.
- One natural sub-module: tick_gen, the DIV_LEN prescaler with clear input and tick output. It is reusable for other timed LED effects.
- The gamma multiply stays inline.

Test Plan:
1. CTR_LEN=8, HOLD_STEPS=4, GAMMA=0, step_div=0, en=1 from cycle 0 -> value counts 0..255 in unit steps, holds 255 for 4 cycles, then counts down to 0 and holds for 4 cycles. Peak and trough each pulse exactly once; period = 518 cycles.
2. step_div=3 -> level changes exactly every 4 cycles; peak first asserts at cycle 1 + 255*4 after leaving IDLE.
3. en dropped while level=100 in FALL -> next cycle state IDLE, level=0, value=0 one cycle later, no trough pulse. Re-enable restarts at 0 in RISE with dir=1.
4. GAMMA=1, step_div=0 -> value sequence follows (n*n)>>8: level 16->1, 128->64, 255->254. Value lags level by exactly one cycle.
5. rst_n pulsed low mid-HOLD_HI, not aligned to clk -> all outputs 0 immediately. After release with en=1, ramp restarts from 0.
6. step_div changed from 1000 to 2 while pre=500 -> tick on the next cycle, then every 3 cycles; no level wrap, no missed state transition.

Source files
------------

// File: rtl/breathe_gen_pkg.sv
// Shared definitions for the breathing-envelope generator.
// Holds the FSM state encodings and the full-scale level derivation
// used by breathe_gen and anything else that needs to decode its state.
package breathe_gen_pkg;

    // FSM state encodings
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RISE    = 3'd1;
    localparam logic [2:0] ST_HOLD_HI = 3'd2;
    localparam logic [2:0] ST_FALL    = 3'd3;
    localparam logic [2:0] ST_HOLD_LO = 3'd4;

    // Full-scale level for a counter of the given width (2^len - 1).
    function automatic int unsigned max_level(input int unsigned len);
        return (32'd1 << len) - 32'd1;
    endfunction

endpackage

// File: rtl/breathe_gen_tick_gen.sv
// Purpose: programmable prescaler; tick fires once every step_div+1 cycles.
// Latency: tick is combinational from the registered count; count clears on tick or clr.
// Backpressure: none; clr holds the count at zero and suppresses tick.
// Ports: clk, rst_n (async, active-low), clr (hold/restart), step_div (period-1), tick (pulse).
module breathe_gen_tick_gen #(
    parameter int DIV_LEN = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic [DIV_LEN-1:0] step_div,
    output logic               tick
);

    logic [DIV_LEN-1:0] pre_q;
    logic [DIV_LEN-1:0] pre_d;

    // ">=" rather than "==" so that lowering step_div below the current
    // count ticks on the next cycle instead of wrapping all the way round.
    always_comb begin
        tick  = !clr && (pre_q >= step_div);
        pre_d = pre_q + 1'b1;
        if (clr || tick) begin
            pre_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/breathe_gen.sv
// Purpose: triangle "breathing" envelope with dwell at top/bottom, optional gamma, feeding the PWM compare.
// Latency: value is registered one cycle behind the internal level; dir/peak/trough registered with state.
// Backpressure: none; en low returns to IDLE (level 0) on the next cycle and overrides any tick.
// Ports: clk, rst_n (async, active-low), en, step_div (tick period-1) -> value, dir, peak, trough.
module breathe_gen
    import breathe_gen_pkg::*;
#(
    parameter int CTR_LEN    = 8,
    parameter int DIV_LEN    = 16,
    parameter int HOLD_STEPS = 32,
    parameter int GAMMA      = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [DIV_LEN-1:0] step_div,
    output logic [CTR_LEN-1:0] value,
    output logic               dir,
    output logic               peak,
    output logic               trough
);

    localparam int HOLD_W = 16;
    localparam logic [CTR_LEN-1:0] MAX       = CTR_LEN'(max_level(CTR_LEN));
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_STEPS - 1);

    logic [2:0]           state_q,  state_d;
    logic [CTR_LEN-1:0]   level_q,  level_d;
    logic [HOLD_W-1:0]    hold_q,   hold_d;
    logic [CTR_LEN-1:0]   value_q,  value_d;
    logic                 dir_q,    dir_d;
    logic                 peak_q,   peak_d;
    logic                 trough_q, trough_d;
    logic [2*CTR_LEN-1:0] sq;
    logic                 tick;
    logic                 tick_clr;

    // The prescaler only runs while ramping/holding; dropping en clears it
    // in the same cycle so a coincident tick is discarded.
    assign tick_clr = !en || (state_q == ST_IDLE);

    breathe_gen_tick_gen #(
        .DIV_LEN (DIV_LEN)
    ) u_tick_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (tick_clr),
        .step_div (step_div),
        .tick     (tick)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            level_q  <= '0;
            hold_q   <= '0;
            value_q  <= '0;
            dir_q    <= 1'b0;
            peak_q   <= 1'b0;
            trough_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            hold_q   <= hold_d;
            value_q  <= value_d;
            dir_q    <= dir_d;
            peak_q   <= peak_d;
            trough_q <= trough_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        hold_d  = hold_q;
        if (!en) begin
            state_d = ST_IDLE;
            level_d = '0;
            hold_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_RISE;
                    level_d = '0;
                    hold_d  = '0;
                end
                ST_RISE: begin
                    if (tick) begin
                        level_d = level_q + 1'b1;
                        if (level_q == MAX - 1'b1) begin
                            state_d = ST_HOLD_HI;
                            hold_d  = '0;
                        end
                    end
                end
                ST_HOLD_HI, ST_HOLD_LO: begin
                    if (tick) begin
                        if (hold_q == HOLD_LAST) begin
                            state_d = (state_q == ST_HOLD_HI) ? ST_FALL : ST_RISE;
                            hold_d  = '0;
                        end else begin
                            hold_d = hold_q + 1'b1;
                        end
                    end
                end
                ST_FALL: begin
                    if (tick) begin
                        level_d = level_q - 1'b1;
                        if (level_q == CTR_LEN'(1)) begin
                            state_d = ST_HOLD_LO;
                            hold_d  = '0;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    level_d = '0;
                    hold_d  = '0;
                end
            endcase
        end
    end

    // Output logic; tick is already forced low when en is low, so the
    // pulses cannot fire on the cycle en drops.
    always_comb begin
        sq       = {{CTR_LEN{1'b0}}, level_q} * {{CTR_LEN{1'b0}}, level_q};
        value_d  = (GAMMA != 0) ? CTR_LEN'(sq >> CTR_LEN) : level_q;
        dir_d    = (state_d == ST_RISE) || (state_d == ST_HOLD_HI);
        peak_d   = (state_q == ST_RISE) && tick && (level_q == MAX - 1'b1);
        trough_d = (state_q == ST_FALL) && tick && (level_q == CTR_LEN'(1));
    end

    assign value  = value_q;
    assign dir    = dir_q;
    assign peak   = peak_q;
    assign trough = trough_q;

endmodule

// File: tb/tb_breathe_gen.sv
module tb_breathe_gen;

    localparam int MAXL = 255;
    localparam int H    = 4;
    localparam int P    = 2 * MAXL + 2 * H;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [15:0] step_div = 16'd0;

    logic [7:0]  v0, v1;
    logic        d0, pk0, tr0, d1, pk1, tr1;

    breathe_gen #(.CTR_LEN(8), .DIV_LEN(16), .HOLD_STEPS(H), .GAMMA(0)) dut_lin (
        .clk(clk), .rst_n(rst_n), .en(en), .step_div(step_div),
        .value(v0), .dir(d0), .peak(pk0), .trough(tr0)
    );

    breathe_gen #(.CTR_LEN(8), .DIV_LEN(16), .HOLD_STEPS(H), .GAMMA(1)) dut_gam (
        .clk(clk), .rst_n(rst_n), .en(en), .step_div(step_div),
        .value(v1), .dir(d1), .peak(pk1), .trough(tr1)
    );

    always #5 clk = ~clk;

    typedef struct {
        int lvl;     // level before the edge -> expected value after it
        bit dir;
        bit peak;
        bit trough;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference model: position p within one envelope period, counted in ticks
    bit m_run = 0;
    int m_p   = 0;
    int m_pre = 0;

    function automatic int level_of(input int p);
        if (p < MAXL)              return p;
        else if (p < MAXL + H)     return MAXL;
        else if (p < 2*MAXL + H)   return MAXL - (p - MAXL - H);
        else                       return 0;
    endfunction

    function automatic void check(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endfunction

    // Advance one clock: model what the DUT does at this edge, queue expectation.
    task automatic cycle();
        exp_t e;
        @(posedge clk);
        e.lvl    = m_run ? level_of(m_p) : 0;
        e.peak   = 0;
        e.trough = 0;
        if (!rst_n) begin
            m_run = 0; m_p = 0; m_pre = 0; e.lvl = 0;
        end else if (!en) begin
            m_run = 0; m_p = 0; m_pre = 0;
        end else if (!m_run) begin
            m_run = 1; m_p = 0; m_pre = 0;
        end else if (m_pre >= int'(step_div)) begin
            m_pre    = 0;
            m_p      = (m_p + 1) % P;
            e.peak   = (m_p == MAXL);
            e.trough = (m_p == 2*MAXL + H);
        end else begin
            m_pre++;
        end
        e.dir = m_run && (m_p < MAXL + H);
        q.push_back(e);
        #1;
    endtask

    // Monitor: compare every registered output once per cycle
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("value_lin",   int'(v0),  e.lvl);
            check("value_gamma", int'(v1),  (e.lvl * e.lvl) >> 8);
            check("dir_lin",     int'(d0),  int'(e.dir));
            check("dir_gamma",   int'(d1),  int'(e.dir));
            check("peak_lin",    int'(pk0), int'(e.peak));
            check("peak_gamma",  int'(pk1), int'(e.peak));
            check("trough_lin",  int'(tr0), int'(e.trough));
            check("trough_gamma",int'(tr1), int'(e.trough));
        end
    end

    initial begin
        int first_pk, second_pk, cnt, pk_at;
        bit found;

        // Reset state
        repeat (3) cycle();
        check("reset_value", int'(v0), 0);
        check("reset_dir",   int'(d0), 0);
        #3 rst_n = 1'b1;

        // Unit-step ramp, period check
        en = 1'b1; step_div = 16'd0;
        first_pk = -1; second_pk = -1;
        for (int i = 0; i < 1100; i++) begin
            cycle();
            if (pk0) begin
                if (first_pk < 0) first_pk = i;
                else if (second_pk < 0) second_pk = i;
            end
        end
        check("peak_period", second_pk - first_pk, P);

        // Slower ramp: first peak arrives 1 + 255*4 cycles after the IDLE cycle
        en = 1'b0; cycle();
        en = 1'b1; step_div = 16'd3;
        cnt = 0; pk_at = -1;
        for (int i = 0; i < 1200; i++) begin
            cycle(); cnt++;
            if (pk0 && pk_at < 0) pk_at = cnt;
        end
        check("first_peak_div3", pk_at, 1 + 255*4);

        // Drop en at level 100 while falling, then re-enable
        step_div = 16'd0;
        found = 0;
        for (int i = 0; i < 3000 && !found; i++) begin
            cycle();
            found = m_run && (m_p == MAXL + H + (MAXL - 100));
        end
        check("reach_fall_100", int'(found), 1);
        en = 1'b0;
        repeat (3) cycle();
        en = 1'b1;
        repeat (300) cycle();

        // Asynchronous reset in the middle of HOLD_HI
        step_div = 16'd5;
        found = 0;
        for (int i = 0; i < 4000 && !found; i++) begin
            cycle();
            found = m_run && (m_p >= MAXL) && (m_p < MAXL + H);
        end
        check("reach_hold_hi", int'(found), 1);
        #7 rst_n = 1'b0;
        m_run = 0; m_p = 0; m_pre = 0;
        #1;
        check("async_value", int'(v0),  0);
        check("async_gamma", int'(v1),  0);
        check("async_dir",   int'(d0),  0);
        check("async_peak",  int'(pk0), 0);
        repeat (2) cycle();
        #3 rst_n = 1'b1;
        step_div = 16'd0;
        repeat (400) cycle();

        // Lower step_div below the running prescaler count
        step_div = 16'd1000;
        found = 0;
        for (int i = 0; i < 2000 && !found; i++) begin
            cycle();
            found = (m_pre == 500);
        end
        check("reach_pre_500", int'(found), 1);
        step_div = 16'd2;
        repeat (600) cycle();

        // Randomized enable drops and step_div changes
        for (int i = 0; i < 15000; i++) begin
            if ($urandom_range(0, 499) == 0) en = 1'b0;
            else if (!en && $urandom_range(0, 2) == 0) en = 1'b1;
            if ($urandom_range(0, 299) == 0) step_div = 16'($urandom_range(0, 4));
            cycle();
        end

        @(negedge clk); #1;
        check("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
